// File: rtl/rr_dual_slot_arbiter.sv
// Round-robin arbiter sharing two resource slots (A, B) among N level requesters,
// with a per-grant hold limit that forces release and pulses expire.
module rr_dual_slot_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [N-1:0] grant_slot,
    output logic [1:0]   slot_busy,
    output logic [N-1:0] expire
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef logic [IW-1:0] idx_t;
    typedef logic [HW-1:0] hold_t;

    localparam hold_t HOLD_MAX = hold_t'(MAX_HOLD);

    idx_t  owner [2];
    hold_t hold  [2];
    idx_t  rr_ptr;

    logic [N-1:0] grant_nxt;
    logic [N-1:0] grant_slot_nxt;
    logic [1:0]   slot_busy_nxt;
    logic [N-1:0] expire_nxt;
    idx_t         owner_nxt [2];
    hold_t        hold_nxt  [2];
    idx_t         rr_ptr_nxt;
    logic [1:0]   free_slots;
    logic [N-1:0] eligible;
    int           cand;

    always_comb begin
        grant_nxt      = grant;
        grant_slot_nxt = grant_slot;
        slot_busy_nxt  = slot_busy;
        expire_nxt     = '0;
        owner_nxt[0]   = owner[0];
        owner_nxt[1]   = owner[1];
        hold_nxt[0]    = hold[0];
        hold_nxt[1]    = hold[1];
        rr_ptr_nxt     = rr_ptr;
        free_slots     = ~slot_busy;
        eligible       = req & ~grant;
        cand           = 0;

        // Releases first: voluntary when req drops, forced once the hold limit is reached.
        for (int s = 0; s < 2; s++) begin
            if (slot_busy[s]) begin
                if (!req[owner[s]] || (hold[s] == HOLD_MAX)) begin
                    free_slots[s]              = 1'b1;
                    slot_busy_nxt[s]           = 1'b0;
                    grant_nxt[owner[s]]        = 1'b0;
                    grant_slot_nxt[owner[s]]   = 1'b0;
                    hold_nxt[s]                = '0;
                    expire_nxt[owner[s]]       = req[owner[s]];
                end else begin
                    hold_nxt[s] = hold[s] + hold_t'(1);
                end
            end
        end

        // Scan from rr_ptr; each winner takes the lowest remaining free slot.
        for (int k = 0; k < N; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N) cand = cand - N;
            if (eligible[cand] && (free_slots != 2'b00)) begin
                grant_nxt[cand] = 1'b1;
                rr_ptr_nxt      = (cand == N - 1) ? '0 : idx_t'(cand + 1);
                if (free_slots[0]) begin
                    free_slots[0]        = 1'b0;
                    slot_busy_nxt[0]     = 1'b1;
                    owner_nxt[0]         = idx_t'(cand);
                    hold_nxt[0]          = hold_t'(1);
                    grant_slot_nxt[cand] = 1'b0;
                end else begin
                    free_slots[1]        = 1'b0;
                    slot_busy_nxt[1]     = 1'b1;
                    owner_nxt[1]         = idx_t'(cand);
                    hold_nxt[1]          = hold_t'(1);
                    grant_slot_nxt[cand] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant      <= '0;
            grant_slot <= '0;
            slot_busy  <= '0;
            expire     <= '0;
            owner[0]   <= '0;
            owner[1]   <= '0;
            hold[0]    <= '0;
            hold[1]    <= '0;
            rr_ptr     <= '0;
        end else begin
            grant      <= grant_nxt;
            grant_slot <= grant_slot_nxt;
            slot_busy  <= slot_busy_nxt;
            expire     <= expire_nxt;
            owner[0]   <= owner_nxt[0];
            owner[1]   <= owner_nxt[1];
            hold[0]    <= hold_nxt[0];
            hold[1]    <= hold_nxt[1];
            rr_ptr     <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_rr_dual_slot_arbiter.sv
// Bench for rr_dual_slot_arbiter: hand-computed vector table, then randomized
// requests checked against a per-requester reference model through a scoreboard queue.
module tb_rr_dual_slot_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int WAIT_BOUND = ((N - 1 + 1) / 2) * (MH + 1) + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant, grant_slot, expire;
    logic [1:0]   slot_busy;

    rr_dual_slot_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_slot (grant_slot),
        .slot_busy  (slot_busy),
        .expire     (expire)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected record layout: {grant, grant_slot, slot_busy, expire}
    logic [13:0] exp_q[$];

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] g;
        logic [3:0] gs;
        logic [1:0] busy;
        logic [3:0] ex;
    } vec_t;

    vec_t vecs[22];

    // Reference model state, tracked per requester rather than per slot.
    logic [3:0] m_g;
    logic [3:0] m_slot;
    int         m_hold[N];
    int         m_ptr;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int limit);
        total++;
        if (act > limit) begin
            bad++;
            $display("FAIL %s: got %0d want <= %0d", name, act, limit);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] q);
        logic [3:0] ng, ns, ex, elig;
        logic       used_a, used_b;
        int         nptr, i;
        ng = m_g; ns = m_slot; ex = '0; nptr = m_ptr;
        if (!r) begin
            m_g = '0; m_slot = '0; m_ptr = 0;
            for (int j = 0; j < N; j++) m_hold[j] = 0;
            exp_q.push_back(14'd0);
        end else begin
            for (int j = 0; j < N; j++) begin
                if (m_g[j] && !q[j]) begin
                    ng[j] = 1'b0;
                end else if (m_g[j] && m_hold[j] == MH) begin
                    ng[j] = 1'b0;
                    ex[j] = 1'b1;
                end
            end
            used_a = 1'b0; used_b = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (ng[j] && !m_slot[j]) used_a = 1'b1;
                if (ng[j] &&  m_slot[j]) used_b = 1'b1;
            end
            elig = q & ~m_g;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (elig[i] && !(used_a && used_b)) begin
                    ng[i] = 1'b1;
                    if (!used_a) begin ns[i] = 1'b0; used_a = 1'b1; end
                    else         begin ns[i] = 1'b1; used_b = 1'b1; end
                    nptr = (i + 1) % N;
                end
            end
            for (int j = 0; j < N; j++) begin
                if (!ng[j])      begin m_hold[j] = 0; ns[j] = 1'b0; end
                else if (!m_g[j]) m_hold[j] = 1;
                else if (m_hold[j] < MH) m_hold[j] = m_hold[j] + 1;
            end
            m_g = ng; m_slot = ns; m_ptr = nptr;
            exp_q.push_back({ng, ns, used_b, used_a, ex});
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] q);
        logic [13:0] e;
        @(negedge clk);
        rst_n = r;
        req   = q;
        model_step(r, q);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got no expected entry want one");
        end else begin
            e = exp_q.pop_front();
            chk("sb_grant",  grant,      e[13:10]);
            chk("sb_slot",   grant_slot, e[9:6]);
            chk("sb_busy",   {2'b00, slot_busy}, {2'b00, e[5:4]});
            chk("sb_expire", expire,     e[3:0]);
        end
    endtask

    function automatic vec_t mkv(input logic r, input logic [3:0] q, input logic [3:0] g,
                                 input logic [3:0] gs, input logic [1:0] b, input logic [3:0] ex);
        vec_t v;
        v.rst_n = r; v.req = q; v.g = g; v.gs = gs; v.busy = b; v.ex = ex;
        return v;
    endfunction

    int run_len[N];
    int wait_len[N];

    initial begin
        m_g = '0; m_slot = '0; m_ptr = 0;
        for (int j = 0; j < N; j++) m_hold[j] = 0;

        // Reset, rotation with forced release and same-edge reallocation.
        vecs[0]  = mkv(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000);
        vecs[1]  = mkv(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b00, 4'b0000);
        vecs[2]  = mkv(1'b1, 4'b1111, 4'b0011, 4'b0010, 2'b11, 4'b0000);
        vecs[3]  = mkv(1'b1, 4'b1111, 4'b0011, 4'b0010, 2'b11, 4'b0000);
        vecs[4]  = mkv(1'b1, 4'b1111, 4'b0011, 4'b0010, 2'b11, 4'b0000);
        vecs[5]  = mkv(1'b1, 4'b1111, 4'b0011, 4'b0010, 2'b11, 4'b0000);
        vecs[6]  = mkv(1'b1, 4'b1111, 4'b1100, 4'b1000, 2'b11, 4'b0011);
        vecs[7]  = mkv(1'b1, 4'b1111, 4'b1100, 4'b1000, 2'b11, 4'b0000);
        vecs[8]  = mkv(1'b1, 4'b1111, 4'b1100, 4'b1000, 2'b11, 4'b0000);
        vecs[9]  = mkv(1'b1, 4'b1111, 4'b1100, 4'b1000, 2'b11, 4'b0000);
        vecs[10] = mkv(1'b1, 4'b1111, 4'b0011, 4'b0010, 2'b11, 4'b1100);
        // Zero-bubble handoff of slot B from 1 to 2, then req3 pulse while full.
        vecs[11] = mkv(1'b1, 4'b1101, 4'b0101, 4'b0100, 2'b11, 4'b0000);
        vecs[12] = mkv(1'b1, 4'b0101, 4'b0101, 4'b0100, 2'b11, 4'b0000);
        vecs[13] = mkv(1'b1, 4'b1101, 4'b0101, 4'b0100, 2'b11, 4'b0000);
        vecs[14] = mkv(1'b1, 4'b0101, 4'b0100, 4'b0100, 2'b10, 4'b0001);
        vecs[15] = mkv(1'b1, 4'b0101, 4'b0001, 4'b0000, 2'b01, 4'b0100);
        vecs[16] = mkv(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000);
        // Single requester on slot A, voluntary drop.
        vecs[17] = mkv(1'b1, 4'b0100, 4'b0100, 4'b0000, 2'b01, 4'b0000);
        vecs[18] = mkv(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000);
        // Pointer sits at 3 here; reset mid-grant restarts it at 0.
        vecs[19] = mkv(1'b1, 4'b1111, 4'b1001, 4'b0001, 2'b11, 4'b0000);
        vecs[20] = mkv(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b00, 4'b0000);
        vecs[21] = mkv(1'b1, 4'b1111, 4'b0011, 4'b0010, 2'b11, 4'b0000);

        for (int v = 0; v < 22; v++) begin
            apply(vecs[v].rst_n, vecs[v].req);
            chk($sformatf("v%0d_grant", v),  grant,      vecs[v].g);
            chk($sformatf("v%0d_slot", v),   grant_slot, vecs[v].gs);
            chk($sformatf("v%0d_busy", v),   {2'b00, slot_busy}, {2'b00, vecs[v].busy});
            chk($sformatf("v%0d_expire", v), expire,     vecs[v].ex);
        end

        for (int j = 0; j < N; j++) begin run_len[j] = 0; wait_len[j] = 0; end

        for (int c = 0; c < 4000; c++) begin
            logic [3:0] q;
            logic       r;
            q = req;
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 7) == 0) q[j] = ~q[j];
            r = ($urandom_range(0, 499) != 0);
            apply(r, q);

            chk_le("inv_popcount", $countones(grant), 2);
            chk_le("inv_busy_count", ($countones(slot_busy) == $countones(grant)) ? 0 : 1, 0);
            chk("inv_expire_vs_grant", expire & grant, 4'b0000);
            if ($countones(grant) == 2)
                chk_le("inv_slot_unique", ($countones(grant_slot & grant) == 1) ? 0 : 1, 0);

            for (int j = 0; j < N; j++) begin
                if (!r) begin
                    run_len[j] = 0; wait_len[j] = 0;
                end else begin
                    if (grant[j]) begin
                        run_len[j]++;
                        chk_le($sformatf("grant_width_%0d", j), run_len[j], MH);
                    end else begin
                        run_len[j] = 0;
                    end
                    if (q[j] && !grant[j]) begin
                        wait_len[j]++;
                        chk_le($sformatf("wait_bound_%0d", j), wait_len[j], WAIT_BOUND);
                    end else begin
                        wait_len[j] = 0;
                    end
                end
            end
        end

        chk_le("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
